// File: rtl/lif_neuron_array_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lif_neuron_array_if : beat bundle between neuron SRAM read, update, WB     |
// | Optional macro: LIF_REFRAC_EN (adds in_refrac/out_refrac). Revision: 1.0   |
// +--------------------------------------------------------------------------+
interface lif_neuron_array_if #(
  parameter int LANES        = 4,
  parameter int TIME_STEP    = 8,
  parameter int MEM_WIDTH    = 12,
  parameter int WEIGHT_WIDTH = 8
);
  localparam int TSW = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1;

  logic                            in_valid;
  logic                            in_ready;
  logic [1:0]                      in_op;
  logic [LANES-1:0]                in_lane_en;
  logic [TSW-1:0]                  in_time_step;
  logic [MEM_WIDTH-1:0]            in_thr;
  logic [LANES*MEM_WIDTH-1:0]      in_state;
  logic [LANES*WEIGHT_WIDTH-1:0]   in_weight;
  logic [LANES*TIME_STEP-1:0]      in_spk_map;
  logic                            out_valid;
  logic                            out_ready;
  logic [LANES*MEM_WIDTH-1:0]      out_state;
  logic [LANES*TIME_STEP-1:0]      out_spk_map;
  logic [LANES-1:0]                out_spike;
`ifdef LIF_REFRAC_EN
  logic [2*LANES-1:0]              in_refrac;
  logic [2*LANES-1:0]              out_refrac;

  modport slave (
    input  in_valid, in_op, in_lane_en, in_time_step, in_thr, in_state,
           in_weight, in_spk_map, out_ready, in_refrac,
    output in_ready, out_valid, out_state, out_spk_map, out_spike, out_refrac
  );
  modport master (
    output in_valid, in_op, in_lane_en, in_time_step, in_thr, in_state,
           in_weight, in_spk_map, out_ready, in_refrac,
    input  in_ready, out_valid, out_state, out_spk_map, out_spike, out_refrac
  );
`else
  modport slave (
    input  in_valid, in_op, in_lane_en, in_time_step, in_thr, in_state,
           in_weight, in_spk_map, out_ready,
    output in_ready, out_valid, out_state, out_spk_map, out_spike
  );
  modport master (
    output in_valid, in_op, in_lane_en, in_time_step, in_thr, in_state,
           in_weight, in_spk_map, out_ready,
    input  in_ready, out_valid, out_state, out_spk_map, out_spike
  );
`endif
endinterface
`default_nettype wire

// File: rtl/lif_neuron_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lif_neuron_array : multi-lane 2-stage LIF update with valid/ready         |
// | Optional macro: LIF_REFRAC_EN (refractory counters). Revision: 1.0        |
// +--------------------------------------------------------------------------+
module lif_neuron_array #(
  parameter int LANES         = 4,
  parameter int TIME_STEP     = 8,
  parameter int MEM_WIDTH     = 12,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int LEAK_SHIFT    = 0,
  parameter int RESET_MODE    = 0,
  parameter int REFRAC_PERIOD = 2
) (
  input wire               CLK,
  input wire               RST,
  lif_neuron_array_if.slave bus
);
  localparam int TSW = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1;
  localparam int MW  = MEM_WIDTH;
  localparam int WW  = WEIGHT_WIDTH;

  localparam logic [1:0] c_OP_ACC  = 2'b01;
  localparam logic [1:0] c_OP_STEP = 2'b10;
  localparam logic [1:0] c_OP_REF  = 2'b11;

  localparam logic signed [MW:0] c_SAT_MAX = {2'b00, {(MW-1){1'b1}}};
  localparam logic signed [MW:0] c_SAT_MIN = {2'b11, {(MW-1){1'b0}}};

  function automatic logic signed [MW-1:0] f_sat(input logic signed [MW:0] x);
    if (x > c_SAT_MAX)      f_sat = c_SAT_MAX[MW-1:0];
    else if (x < c_SAT_MIN) f_sat = c_SAT_MIN[MW-1:0];
    else                    f_sat = x[MW-1:0];
  endfunction

  logic                          r_s1_valid;
  logic [1:0]                    r_s1_op;
  logic [LANES-1:0]              r_s1_en;
  logic [TSW-1:0]                r_s1_ts;
  logic signed [MW-1:0]          r_s1_thr;
  logic [LANES*MW-1:0]           r_s1_state;
  logic [LANES*WW-1:0]           r_s1_weight;
  logic [LANES*TIME_STEP-1:0]    r_s1_map;

  logic                          r_s2_valid;
  logic [LANES*MW-1:0]           r_s2_state;
  logic [LANES*TIME_STEP-1:0]    r_s2_map;
  logic [LANES-1:0]              r_s2_spike;

  logic [LANES*MW-1:0]           w_state_n;
  logic [LANES*TIME_STEP-1:0]    w_map_n;
  logic [LANES-1:0]              w_spike_n;

  logic                          w_s2_adv;
  logic                          w_in_ready;

`ifdef LIF_REFRAC_EN
  logic [2*LANES-1:0]            r_s1_refrac;
  logic [2*LANES-1:0]            r_s2_refrac;
  logic [2*LANES-1:0]            w_refrac_n;
  assign bus.out_refrac = r_s2_refrac;
`endif

  // Stage 2 drains when empty or consumed; stage 1 refills whenever it will be vacated.
  assign w_s2_adv   = !r_s2_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_adv;

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_s2_valid;
  assign bus.out_state   = r_s2_state;
  assign bus.out_spk_map = r_s2_map;
  assign bus.out_spike   = r_s2_spike;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [MW-1:0]       w_st;
    logic signed [WW-1:0]       w_wt;
    logic signed [MW:0]         w_st_ext;
    logic signed [MW:0]         w_wt_ext;
    logic signed [MW:0]         w_thr_ext;
    logic signed [MW:0]         w_lk_ext;
    logic signed [MW:0]         w_acc_sum;
    logic signed [MW:0]         w_sub;
    logic signed [MW-1:0]       w_leaked;
    logic signed [MW-1:0]       w_relu;
    logic [TIME_STEP-1:0]       w_mp;
    logic                       w_busy;
    logic                       w_fire;
    logic signed [MW-1:0]       w_st_n;
    logic [TIME_STEP-1:0]       w_mp_n;
    logic                       w_sp_n;

    assign w_st      = r_s1_state[l*MW +: MW];
    assign w_wt      = r_s1_weight[l*WW +: WW];
    assign w_mp      = r_s1_map[l*TIME_STEP +: TIME_STEP];
    assign w_st_ext  = {w_st[MW-1], w_st};
    assign w_wt_ext  = {{(MW+1-WW){w_wt[WW-1]}}, w_wt};
    assign w_thr_ext = {r_s1_thr[MW-1], r_s1_thr};
    assign w_lk_ext  = {w_leaked[MW-1], w_leaked};
    assign w_acc_sum = w_st_ext + w_wt_ext;
    assign w_sub     = w_lk_ext - w_thr_ext;

    if (LEAK_SHIFT > 0) begin : g_leak
      assign w_leaked = w_st - (w_st >>> LEAK_SHIFT);
    end else begin : g_no_leak
      assign w_leaked = w_st;
    end

    assign w_relu = w_leaked[MW-1] ? '0 : w_leaked;
    assign w_fire = (w_leaked >= r_s1_thr) && !w_busy;

`ifdef LIF_REFRAC_EN
    logic [1:0] w_rf;
    logic [1:0] w_rf_n;
    assign w_rf   = r_s1_refrac[2*l +: 2];
    assign w_busy = |w_rf;
    assign w_refrac_n[2*l +: 2] = w_rf_n;
`else
    assign w_busy = 1'b0;
`endif

    always_comb begin
      w_st_n = w_st;
      w_mp_n = w_mp;
      w_sp_n = 1'b0;
`ifdef LIF_REFRAC_EN
      w_rf_n = w_rf;
`endif
      if (r_s1_en[l]) begin
        case (r_s1_op)
          c_OP_ACC: begin
            if (!w_busy) w_st_n = f_sat(w_acc_sum);
          end
          c_OP_STEP: begin
            if (w_fire) begin
              w_sp_n = 1'b1;
              // Out-of-range time steps match no bit, so the bitmap is left alone.
              for (int t = 0; t < TIME_STEP; t++) begin
                if (r_s1_ts == TSW'(t)) w_mp_n[t] = 1'b1;
              end
              if (RESET_MODE == 1) w_st_n = f_sat(w_sub);
              else                 w_st_n = '0;
`ifdef LIF_REFRAC_EN
              w_rf_n = 2'(REFRAC_PERIOD);
`endif
            end else begin
              w_st_n = w_relu;
`ifdef LIF_REFRAC_EN
              if (w_busy) w_rf_n = w_rf - 2'd1;
`endif
            end
          end
          c_OP_REF: begin
            w_st_n = '0;
            w_mp_n = '0;
`ifdef LIF_REFRAC_EN
            w_rf_n = 2'd0;
`endif
          end
          default: ;
        endcase
      end
    end

    assign w_state_n[l*MW +: MW]              = w_st_n;
    assign w_map_n[l*TIME_STEP +: TIME_STEP]  = w_mp_n;
    assign w_spike_n[l]                       = w_sp_n;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_state <= '0;
      r_s2_map   <= '0;
      r_s2_spike <= '0;
`ifdef LIF_REFRAC_EN
      r_s2_refrac <= '0;
`endif
    end else begin
      if (w_in_ready) r_s1_valid <= bus.in_valid;
      if (w_s2_adv)   r_s2_valid <= r_s1_valid;
      if (w_s2_adv && r_s1_valid) begin
        r_s2_state <= w_state_n;
        r_s2_map   <= w_map_n;
        r_s2_spike <= w_spike_n;
`ifdef LIF_REFRAC_EN
        r_s2_refrac <= w_refrac_n;
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_in_ready && bus.in_valid) begin
      r_s1_op     <= bus.in_op;
      r_s1_en     <= bus.in_lane_en;
      r_s1_ts     <= bus.in_time_step;
      r_s1_thr    <= bus.in_thr;
      r_s1_state  <= bus.in_state;
      r_s1_weight <= bus.in_weight;
      r_s1_map    <= bus.in_spk_map;
`ifdef LIF_REFRAC_EN
      r_s1_refrac <= bus.in_refrac;
`endif
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_lif_neuron_array.sv
`default_nettype none
// Bench for lif_neuron_array: directed cases plus randomized traffic against a
// behavioural model; DUT B uses LEAK_SHIFT=2, RESET_MODE=1. Honours LIF_REFRAC_EN.
module tb_lif_neuron_array;
  localparam int L = 4, TS = 8, MW = 12, WW = 8, TSW = 3, RP = 2;
`ifdef LIF_REFRAC_EN
  localparam bit c_REFRAC = 1'b1;
`else
  localparam bit c_REFRAC = 1'b0;
`endif

  typedef struct packed {
    logic [L*MW-1:0] st;
    logic [L*TS-1:0] mp;
    logic [L-1:0]    sp;
    logic [2*L-1:0]  rf;
  } res_t;
  typedef struct packed { res_t a; res_t b; } pair_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  lif_neuron_array_if #(.LANES(L), .TIME_STEP(TS), .MEM_WIDTH(MW), .WEIGHT_WIDTH(WW)) bus_a ();
  lif_neuron_array_if #(.LANES(L), .TIME_STEP(TS), .MEM_WIDTH(MW), .WEIGHT_WIDTH(WW)) bus_b ();

  logic [2*L-1:0] drv_rf = '0;
  logic [2*L-1:0] rf_out_a, rf_out_b;
  assign bus_b.in_valid     = bus_a.in_valid;
  assign bus_b.in_op        = bus_a.in_op;
  assign bus_b.in_lane_en   = bus_a.in_lane_en;
  assign bus_b.in_time_step = bus_a.in_time_step;
  assign bus_b.in_thr       = bus_a.in_thr;
  assign bus_b.in_state     = bus_a.in_state;
  assign bus_b.in_weight    = bus_a.in_weight;
  assign bus_b.in_spk_map   = bus_a.in_spk_map;
  assign bus_b.out_ready    = bus_a.out_ready;
`ifdef LIF_REFRAC_EN
  assign bus_a.in_refrac = drv_rf;
  assign bus_b.in_refrac = drv_rf;
  assign rf_out_a = bus_a.out_refrac;
  assign rf_out_b = bus_b.out_refrac;
`else
  assign rf_out_a = '0;
  assign rf_out_b = '0;
`endif

  lif_neuron_array #(.LANES(L), .TIME_STEP(TS), .MEM_WIDTH(MW), .WEIGHT_WIDTH(WW),
                     .LEAK_SHIFT(0), .RESET_MODE(0), .REFRAC_PERIOD(RP))
    u_dut_a (.CLK(CLK), .RST(RST), .bus(bus_a));
  lif_neuron_array #(.LANES(L), .TIME_STEP(TS), .MEM_WIDTH(MW), .WEIGHT_WIDTH(WW),
                     .LEAK_SHIFT(2), .RESET_MODE(1), .REFRAC_PERIOD(RP))
    u_dut_b (.CLK(CLK), .RST(RST), .bus(bus_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int x);
    int hi, lo;
    hi = (1 << (MW-1)) - 1;
    lo = -(1 << (MW-1));
    sat = (x > hi) ? hi : ((x < lo) ? lo : x);
  endfunction

  function automatic int relu(input int x);
    relu = (x < 0) ? 0 : x;
  endfunction

  function automatic res_t model(input logic [1:0] op, input logic [L-1:0] en,
                                 input logic [TSW-1:0] ts, input logic [MW-1:0] thr_v,
                                 input logic [L*MW-1:0] st, input logic [L*WW-1:0] wt,
                                 input logic [L*TS-1:0] mp, input logic [2*L-1:0] rf,
                                 input int ls, input int rm);
    res_t r;
    int s, w, thr, lk, rfv;
    r.st = st; r.mp = mp; r.sp = '0; r.rf = c_REFRAC ? rf : '0;
    thr = int'($signed(thr_v));
    for (int l = 0; l < L; l++) begin
      s   = int'($signed(st[l*MW +: MW]));
      w   = int'($signed(wt[l*WW +: WW]));
      rfv = c_REFRAC ? int'(rf[2*l +: 2]) : 0;
      if (en[l]) begin
        case (op)
          2'd1: if (rfv == 0) s = sat(s + w);
          2'd2: begin
            lk = (ls > 0) ? s - (s >>> ls) : s;
            if (rfv != 0) begin
              rfv = rfv - 1;
              s = relu(lk);
            end else if (lk >= thr) begin
              r.sp[l] = 1'b1;
              if (int'(ts) < TS) r.mp[l*TS + int'(ts)] = 1'b1;
              s = (rm == 1) ? sat(lk - thr) : 0;
              rfv = RP;
            end else begin
              s = relu(lk);
            end
          end
          2'd3: begin s = 0; r.mp[l*TS +: TS] = '0; rfv = 0; end
          default: ;
        endcase
        r.st[l*MW +: MW] = s[MW-1:0];
        if (c_REFRAC) r.rf[2*l +: 2] = rfv[1:0];
      end
    end
    return r;
  endfunction

  pair_t exp_q[$];
  pair_t mon_e;
  res_t  mon_oa, mon_ob, prev_a, prev_b;
  bit    prev_stall = 1'b0;

  always @(negedge CLK) begin
    if (RST) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      mon_oa = {bus_a.out_state, bus_a.out_spk_map, bus_a.out_spike, rf_out_a};
      mon_ob = {bus_b.out_state, bus_b.out_spk_map, bus_b.out_spike, rf_out_b};
      check("b_valid_match", 128'(bus_b.out_valid), 128'(bus_a.out_valid));
      if (prev_stall) begin
        check("hold_a", 128'(mon_oa), 128'(prev_a));
        check("hold_b", 128'(mon_ob), 128'(prev_b));
      end
      if (bus_a.out_valid && bus_a.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 128'(1), 128'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("a_state", 128'(mon_oa.st), 128'(mon_e.a.st));
          check("a_map",   128'(mon_oa.mp), 128'(mon_e.a.mp));
          check("a_spike", 128'(mon_oa.sp), 128'(mon_e.a.sp));
          check("b_state", 128'(mon_ob.st), 128'(mon_e.b.st));
          check("b_map",   128'(mon_ob.mp), 128'(mon_e.b.mp));
          check("b_spike", 128'(mon_ob.sp), 128'(mon_e.b.sp));
`ifdef LIF_REFRAC_EN
          check("a_refrac", 128'(mon_oa.rf), 128'(mon_e.a.rf));
          check("b_refrac", 128'(mon_ob.rf), 128'(mon_e.b.rf));
`endif
        end
      end
      if (bus_a.in_valid && bus_a.in_ready) begin
        mon_e.a = model(bus_a.in_op, bus_a.in_lane_en, bus_a.in_time_step, bus_a.in_thr,
                        bus_a.in_state, bus_a.in_weight, bus_a.in_spk_map, drv_rf, 0, 0);
        mon_e.b = model(bus_a.in_op, bus_a.in_lane_en, bus_a.in_time_step, bus_a.in_thr,
                        bus_a.in_state, bus_a.in_weight, bus_a.in_spk_map, drv_rf, 2, 1);
        exp_q.push_back(mon_e);
      end
      prev_stall = bus_a.out_valid && !bus_a.out_ready;
      prev_a = mon_oa;
      prev_b = mon_ob;
    end
  end

  task automatic rand_beat(input bit force_acc);
    logic [MW-1:0] tmp;
    bus_a.in_op        = force_acc ? 2'd1 : 2'($urandom_range(0, 3));
    bus_a.in_lane_en   = L'($urandom);
    bus_a.in_time_step = TSW'($urandom);
    bus_a.in_thr       = MW'(int'($urandom_range(0, 400)) - 200);
    bus_a.in_weight    = (L*WW)'($urandom);
    bus_a.in_spk_map   = (L*TS)'($urandom);
    drv_rf             = (2*L)'($urandom);
    for (int l = 0; l < L; l++) begin
      case ($urandom_range(0, 3))
        0:       tmp = MW'(12'h7F0 + 12'($urandom_range(0, 15)));
        1:       tmp = MW'(12'h800 + 12'($urandom_range(0, 15)));
        2:       tmp = MW'($urandom_range(0, 300));
        default: tmp = MW'($urandom);
      endcase
      bus_a.in_state[l*MW +: MW] = tmp;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [L-1:0] en, input logic [TSW-1:0] ts,
                      input logic [MW-1:0] thr, input logic [L*MW-1:0] st,
                      input logic [L*WW-1:0] wt, input logic [L*TS-1:0] mp,
                      input logic [2*L-1:0] rf, output res_t ra, output res_t rb,
                      output int lat);
    int n;
    @(posedge CLK); #1;
    bus_a.in_valid = 1'b1; bus_a.in_op = op; bus_a.in_lane_en = en;
    bus_a.in_time_step = ts; bus_a.in_thr = thr; bus_a.in_state = st;
    bus_a.in_weight = wt; bus_a.in_spk_map = mp; drv_rf = rf;
    n = 0;
    do begin @(negedge CLK); n++; end while (!bus_a.in_ready && n < 20);
    if (!bus_a.in_ready) check("accept_timeout", 128'(0), 128'(1));
    @(posedge CLK); #1;
    bus_a.in_valid = 1'b0;
    lat = 0;
    while (1) begin
      @(negedge CLK); lat++;
      if (bus_a.out_valid || lat >= 20) break;
    end
    if (!bus_a.out_valid) check("result_timeout", 128'(0), 128'(1));
    ra = {bus_a.out_state, bus_a.out_spk_map, bus_a.out_spike, rf_out_a};
    rb = {bus_b.out_state, bus_b.out_spk_map, bus_b.out_spike, rf_out_b};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t ra, rb;
    int   lat, k, cyc, guard;

    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    bus_a.in_op = '0; bus_a.in_lane_en = '0; bus_a.in_time_step = '0; bus_a.in_thr = '0;
    bus_a.in_state = '0; bus_a.in_weight = '0; bus_a.in_spk_map = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_out_valid", 128'(bus_a.out_valid),   128'(0));
    check("rst_in_ready",  128'(bus_a.in_ready),    128'(1));
    check("rst_out_state", 128'(bus_a.out_state),   128'(0));
    check("rst_out_map",   128'(bus_a.out_spk_map), 128'(0));
    check("rst_out_spike", 128'(bus_a.out_spike),   128'(0));

    send(2'd1, 4'b0001, 3'd0, 12'd100, 48'(12'd2040), 32'(8'd20), '0, '0, ra, rb, lat);
    check("latency", 128'(lat), 128'(2));
    check("acc_sat_pos", 128'(ra.st[MW-1:0]), 128'(12'h7FF));
    send(2'd1, 4'b0001, 3'd0, 12'd100, 48'(12'h808), 32'(8'hEC), '0, '0, ra, rb, lat);
    check("acc_sat_neg", 128'(ra.st[MW-1:0]), 128'(12'h800));

    send(2'd2, 4'b0001, 3'd3, 12'd100, 48'(12'd150), '0, '0, '0, ra, rb, lat);
    check("fire_spike", 128'(ra.sp), 128'(4'b0001));
    check("fire_state", 128'(ra.st[MW-1:0]), 128'(0));
    check("fire_map",   128'(ra.mp[TS-1:0]), 128'(8'h08));
    check("fire_b_state", 128'(rb.st[MW-1:0]), 128'(12'd13));
    send(2'd2, 4'b0001, 3'd3, 12'd100, 48'(12'hFFB), '0, 32'(8'h41), '0, ra, rb, lat);
    check("relu_state", 128'(ra.st[MW-1:0]), 128'(0));
    check("relu_spike", 128'(ra.sp), 128'(0));
    check("relu_map",   128'(ra.mp[TS-1:0]), 128'(8'h41));

    send(2'd2, 4'b0001, 3'd1, 12'd100, 48'(12'd200), '0, '0, '0, ra, rb, lat);
    check("sub_thr_state", 128'(rb.st[MW-1:0]), 128'(12'd50));
    check("sub_thr_spike", 128'(rb.sp), 128'(4'b0001));
    send(2'd2, 4'b0001, 3'd1, 12'd100, 48'(12'd120), '0, '0, '0, ra, rb, lat);
    check("leak_state", 128'(rb.st[MW-1:0]), 128'(12'd90));
    check("leak_spike", 128'(rb.sp), 128'(0));

    send(2'd2, 4'b0001, 3'd5, 12'd0, '0, '0, '0, '0, ra, rb, lat);
    check("thr_zero_spike", 128'(ra.sp), 128'(4'b0001));
    check("thr_zero_map",   128'(ra.mp[TS-1:0]), 128'(8'h20));

    send(2'd3, 4'b0101, 3'd0, 12'd100, 48'h111_222_333_444, 32'h01020304,
         32'hAABBCCDD, '0, ra, rb, lat);
    check("ref_state", 128'(ra.st), 128'(48'h111_000_333_000));
    check("ref_map",   128'(ra.mp), 128'(32'hAA00CC00));
    check("ref_spike", 128'(ra.sp), 128'(0));

`ifdef LIF_REFRAC_EN
    send(2'd2, 4'b0001, 3'd0, 12'd10, 48'(12'd20), '0, '0, '0, ra, rb, lat);
    check("rf_fire_spike", 128'(ra.sp), 128'(4'b0001));
    check("rf_fire_load",  128'(ra.rf[1:0]), 128'(2));
    send(2'd1, 4'b0001, 3'd0, 12'd10, '0, 32'(8'd50), '0, 8'd2, ra, rb, lat);
    check("rf_acc_blocked", 128'(ra.st[MW-1:0]), 128'(0));
    send(2'd2, 4'b0001, 3'd1, 12'd10, '0, '0, '0, 8'd2, ra, rb, lat);
    check("rf_dec1", 128'(ra.rf[1:0]), 128'(1));
    check("rf_dec1_spike", 128'(ra.sp), 128'(0));
    send(2'd2, 4'b0001, 3'd2, 12'd10, '0, '0, '0, 8'd1, ra, rb, lat);
    check("rf_dec0", 128'(ra.rf[1:0]), 128'(0));
    check("rf_dec0_spike", 128'(ra.sp), 128'(0));
    send(2'd1, 4'b0001, 3'd0, 12'd10, '0, 32'(8'd50), '0, 8'd0, ra, rb, lat);
    check("rf_acc_again", 128'(ra.st[MW-1:0]), 128'(12'd50));
`endif

    // Backpressure: six ACC beats with out_ready held low for four cycles.
    @(posedge CLK); #1;
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    rand_beat(1'b1);
    k = 0; cyc = 0; guard = 0;
    while (k < 6 && guard < 100) begin
      @(negedge CLK);
      guard++; cyc++;
      if (cyc == 4) check("bp_in_ready_low", 128'(bus_a.in_ready), 128'(0));
      if (bus_a.in_valid && bus_a.in_ready) begin
        k++;
        @(posedge CLK); #1;
        if (k < 6) rand_beat(1'b1);
      end else begin
        @(posedge CLK); #1;
      end
      if (cyc >= 4) bus_a.out_ready = 1'b1;
    end
    if (k < 6) check("bp_accept_timeout", 128'(k), 128'(6));
    bus_a.in_valid = 1'b0;
    bus_a.out_ready = 1'b1;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    check("bp_drained", 128'(exp_q.size()), 128'(0));

    for (int i = 0; i < 500; i++) begin
      @(posedge CLK); #1;
      bus_a.in_valid  = ($urandom_range(0, 3) != 0);
      bus_a.out_ready = ($urandom_range(0, 3) != 0);
      rand_beat(1'b0);
    end
    @(posedge CLK); #1;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    check("rand_drained", 128'(exp_q.size()), 128'(0));

    // Reset with two beats in flight.
    @(posedge CLK); #1;
    bus_a.in_valid = 1'b1; rand_beat(1'b1);
    @(posedge CLK); #1;
    rand_beat(1'b1);
    @(posedge CLK); #1;
    bus_a.in_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check("pre_rst_full", 128'(bus_a.out_valid), 128'(1));
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("rst_flush_valid", 128'(bus_a.out_valid), 128'(0));
    check("rst_flush_state", 128'(bus_a.out_state), 128'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("no_stale_output", 128'(bus_a.out_valid), 128'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
